// File: rtl/inst_rom_loader.sv
// Instruction memory with a zero-latency fetch port for the core and a byte-stream loader
// that fills it from a host/UART source while holding the core in reset.
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    input  logic                  ld_start,
    input  logic [ADDR_WIDTH:0]   ld_len,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    output logic                  ld_ready,
    output logic                  ld_done,
    output logic                  ld_err,
    output logic                  cpu_hold
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH:0] len_q;
    logic [ADDR_WIDTH:0] word_ptr;
    logic [1:0]          byte_cnt;
    logic [23:0]         shift_q;
    logic                err_q;
    logic [31:0]         mem [DEPTH];

    logic len_ok;
    logic start_ok;
    logic accept;
    logic word_done;
    logic last_word;
    logic unused_addr_bits;

    assign len_ok    = (ld_len != '0) && (ld_len <= MAX_LEN);
    assign start_ok  = (state == IDLE) && ld_start && len_ok;
    assign accept    = (state == LOAD) && ld_valid;
    assign word_done = accept && (byte_cnt == 2'd3);
    // word_ptr carries one extra bit so a full-depth load compares without wrapping
    assign last_word = word_done && ((word_ptr + PTR_ONE) == len_q);

    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok)  state_next = LOAD;
            LOAD:    if (last_word) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = (state == LOAD);
        cpu_hold = (state == LOAD) || (state == DONE);
        ld_done  = (state == DONE);
        ld_err   = err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            word_ptr <= '0;
            byte_cnt <= '0;
            shift_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && ld_start && !len_ok;
            if (start_ok) begin
                len_q    <= ld_len;
                word_ptr <= '0;
                byte_cnt <= '0;
                shift_q  <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word_ptr <= word_ptr + PTR_ONE;
                    shift_q  <= '0;
                end else begin
                    shift_q  <= {shift_q[15:0], ld_byte};
                end
            end
        end
    end

    // Memory contents deliberately survive reset so an aborted load keeps completed words
    always_ff @(posedge clk) begin
        if (word_done) begin
            mem[word_ptr[ADDR_WIDTH-1:0]] <= {shift_q, ld_byte};
        end
    end

    always_comb begin
        inst = '0;
        if (ce && (state != LOAD)) begin
            inst = mem[addr[ADDR_WIDTH+1:2]];
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized self-checking bench for inst_rom_loader against a word-level memory model.
module tb_inst_rom_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [31:0]   addr;
    logic [31:0]   inst;
    logic          ld_start;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_err;
    logic          cpu_hold;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] tx_words [$];
    int          vpat [$];
    int          drv_accepted;
    int          drv_bad;

    inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .addr     (addr),
        .inst     (inst),
        .ld_start (ld_start),
        .ld_len   (ld_len),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    // Sends tx_words as a big-endian byte stream, observing the core-facing outputs each cycle.
    // Returns at the negedge of the cycle following the last accepted byte.
    task automatic run_load(input int len, input int glitch_at, input int bound);
        logic [7:0] bytes [$];
        int idx;
        int cyc;
        int p;
        logic v;
        bytes = {};
        foreach (tx_words[w])
            for (int b = 3; b >= 0; b--) bytes.push_back(tx_words[w][8*b +: 8]);
        drv_accepted = 0;
        drv_bad = 0;
        @(negedge clk);
        ce = 1'b1;
        addr = $urandom;
        ld_start = 1'b1;
        ld_len = len[AW:0];
        @(negedge clk);
        ld_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < bytes.size() && cyc < bound) begin
            if (ld_ready !== 1'b1 || cpu_hold !== 1'b1 || inst !== 32'h0 ||
                ld_done !== 1'b0 || ld_err !== 1'b0)
                drv_bad++;
            if (vpat.size() > 0) begin
                p = vpat.pop_front();
                v = (p != 0);
            end else begin
                v = ($urandom_range(0, 3) != 0);
            end
            ld_start = (cyc == glitch_at);
            if (cyc == glitch_at) ld_len = 11'd5;
            ld_valid = v;
            ld_byte = v ? bytes[idx] : 8'($urandom);
            if (v && ld_ready === 1'b1) begin
                idx++;
                drv_accepted++;
            end
            @(negedge clk);
            addr = $urandom;
            cyc++;
        end
        ld_valid = 1'b0;
        ld_start = 1'b0;
        ce = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ce = 1'b0;
        addr = '0;
        ld_start = 1'b0;
        ld_len = '0;
        ld_valid = 1'b0;
        ld_byte = '0;
        #2;
        checks++;
        if ({ld_ready, ld_done, ld_err, cpu_hold} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000", {ld_ready, ld_done, ld_err, cpu_hold});
        end
        checks++;
        if (inst !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_inst: got %h expected 00000000", inst);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ld_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ld_ready, ld_done, ld_err, cpu_hold} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_outputs: got %b expected 0000", {ld_ready, ld_done, ld_err, cpu_hold});
        end
        ld_valid = 1'b0;
    endtask

    task automatic test_basic_load();
        tx_words = {32'h3401_0005, 32'h3C02_1234};
        vpat = {1, 1, 1, 1, 1, 1, 1, 1};
        run_load(2, -1, 100);
        checks++;
        if (drv_accepted != 8) begin errors++; $display("[TB] FAIL basic_accepted: got %0d expected 8", drv_accepted); end
        checks++;
        if (drv_bad != 0) begin errors++; $display("[TB] FAIL basic_during_load: got %0d bad cycles expected 0", drv_bad); end
        checks++;
        if ({ld_done, ld_ready, cpu_hold, ld_err} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL basic_done_cycle: got %b expected 1010", {ld_done, ld_ready, cpu_hold, ld_err});
        end
        @(negedge clk);
        checks++;
        if ({ld_done, ld_ready, cpu_hold, ld_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL basic_release: got %b expected 0000", {ld_done, ld_ready, cpu_hold, ld_err});
        end
        model_mem[0] = 32'h3401_0005;
        model_mem[1] = 32'h3C02_1234;
        ce = 1'b1;
        addr = 32'h0000_0004;
        #1;
        checks++;
        if (inst !== 32'h3C02_1234) begin errors++; $display("[TB] FAIL basic_fetch4: got %h expected 3c021234", inst); end
        @(negedge clk);
        checks++;
        if (ld_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_once: got %b expected 0", ld_done); end
        addr = 32'hFFFF_F003;
        #1;
        checks++;
        if (inst !== 32'h3401_0005) begin errors++; $display("[TB] FAIL basic_fetch_alias: got %h expected 34010005", inst); end
        ce = 1'b0;
    endtask

    task automatic test_len_errors();
        logic [AW:0] bad_lens [3];
        bad_lens[0] = 11'd0;
        bad_lens[1] = 11'd1025;
        bad_lens[2] = 11'($urandom_range(1026, 2047));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld_start = 1'b1;
            ld_len = bad_lens[i];
            @(negedge clk);
            ld_start = 1'b0;
            checks++;
            if ({ld_err, ld_done, ld_ready, cpu_hold} !== 4'b1000) begin
                errors++;
                $display("[TB] FAIL len_err_pulse[%0d]: got %b expected 1000", bad_lens[i], {ld_err, ld_done, ld_ready, cpu_hold});
            end
            @(negedge clk);
            checks++;
            if ({ld_err, ld_done, ld_ready, cpu_hold} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL len_err_after[%0d]: got %b expected 0000", bad_lens[i], {ld_err, ld_done, ld_ready, cpu_hold});
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic [31:0] w;
        w = $urandom;
        tx_words = {w};
        vpat = {1, 0, 0, 1, 0, 1, 1};
        run_load(1, -1, 50);
        checks++;
        if (drv_accepted != 4) begin errors++; $display("[TB] FAIL gaps_accepted: got %0d expected 4", drv_accepted); end
        checks++;
        if (drv_bad != 0) begin errors++; $display("[TB] FAIL gaps_during_load: got %0d bad cycles expected 0", drv_bad); end
        checks++;
        if ({ld_done, ld_ready, cpu_hold, ld_err} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL gaps_done_cycle: got %b expected 1010", {ld_done, ld_ready, cpu_hold, ld_err});
        end
        @(negedge clk);
        model_mem[0] = w;
        ce = 1'b1;
        addr = 32'h0000_0000;
        #1;
        checks++;
        if (inst !== w) begin errors++; $display("[TB] FAIL gaps_fetch0: got %h expected %h", inst, w); end
        ce = 1'b0;
    endtask

    task automatic test_back_to_back();
        int len;
        int idx;
        for (int n = 0; n < 4; n++) begin
            len = $urandom_range(1, 12);
            tx_words = {};
            for (int i = 0; i < len; i++) tx_words.push_back($urandom);
            run_load(len, -1, 40 * len + 40);
            checks++;
            if (drv_accepted != 4 * len || drv_bad != 0) begin
                errors++;
                $display("[TB] FAIL b2b_load[%0d]: got %0d bytes/%0d bad expected %0d/0", n, drv_accepted, drv_bad, 4 * len);
            end
            checks++;
            if ({ld_done, ld_ready, cpu_hold, ld_err} !== 4'b1010) begin
                errors++;
                $display("[TB] FAIL b2b_done[%0d]: got %b expected 1010", n, {ld_done, ld_ready, cpu_hold, ld_err});
            end
            for (int i = 0; i < len; i++) model_mem[i] = tx_words[i];
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            idx = $urandom_range(0, 11);
            ce = 1'b1;
            addr = $urandom;
            addr[AW+1:2] = idx[AW-1:0];
            #1;
            checks++;
            if (inst !== model_mem[idx]) begin
                errors++;
                $display("[TB] FAIL b2b_fetch[%0d]: got %h expected %h", idx, inst, model_mem[idx]);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [31:0] old3;
        logic [31:0] old4;
        old3 = $urandom;
        old4 = $urandom;
        tx_words = {32'h0, 32'h0, 32'h0, old3, old4};
        run_load(5, -1, 300);
        @(negedge clk);
        for (int i = 0; i < 5; i++) model_mem[i] = tx_words[i];
        tx_words = {};
        for (int i = 0; i < 3; i++) tx_words.push_back($urandom);
        run_load(3, 4, 200);
        checks++;
        if (drv_accepted != 12 || drv_bad != 0) begin
            errors++;
            $display("[TB] FAIL restart_load: got %0d bytes/%0d bad expected 12/0", drv_accepted, drv_bad);
        end
        checks++;
        if ({ld_done, ld_ready, cpu_hold, ld_err} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL restart_done: got %b expected 1010", {ld_done, ld_ready, cpu_hold, ld_err});
        end
        ld_start = 1'b1;
        ld_len = 11'd1;
        @(negedge clk);
        ld_start = 1'b0;
        checks++;
        if ({ld_done, ld_ready, cpu_hold, ld_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL start_in_done: got %b expected 0000", {ld_done, ld_ready, cpu_hold, ld_err});
        end
        for (int i = 0; i < 3; i++) model_mem[i] = tx_words[i];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ce = 1'b1;
            addr = 32'(i * 4);
            #1;
            checks++;
            if (inst !== model_mem[i]) begin
                errors++;
                $display("[TB] FAIL restart_fetch[%0d]: got %h expected %h", i, inst, model_mem[i]);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_reset_during_load();
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  bytes [8];
        w0 = $urandom;
        w1 = ~model_mem[1];
        for (int b = 0; b < 4; b++) begin
            bytes[b]     = w0[31-8*b -: 8];
            bytes[b + 4] = w1[31-8*b -: 8];
        end
        @(negedge clk);
        ld_start = 1'b1;
        ld_len = 11'd2;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1;
            ld_byte = bytes[i];
            @(negedge clk);
        end
        ld_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ld_ready, ld_done, ld_err, cpu_hold} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %b expected 0000", {ld_ready, ld_done, ld_err, cpu_hold});
        end
        model_mem[0] = w0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ce = 1'b1;
            addr = 32'(i * 4);
            #1;
            checks++;
            if (inst !== model_mem[i]) begin
                errors++;
                $display("[TB] FAIL abort_fetch[%0d]: got %h expected %h", i, inst, model_mem[i]);
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_full_fill();
        int idx;
        tx_words = {};
        for (int i = 0; i < DEPTH; i++) tx_words.push_back($urandom);
        run_load(DEPTH, -1, 4 * DEPTH * 3);
        checks++;
        if (drv_accepted != 4 * DEPTH || drv_bad != 0) begin
            errors++;
            $display("[TB] FAIL full_load: got %0d bytes/%0d bad expected %0d/0", drv_accepted, drv_bad, 4 * DEPTH);
        end
        checks++;
        if ({ld_done, ld_ready, cpu_hold, ld_err} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL full_done: got %b expected 1010", {ld_done, ld_ready, cpu_hold, ld_err});
        end
        @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL full_release: got %b expected 0", cpu_hold); end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = tx_words[i];
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            idx = (k == 0) ? 0 : (k == 1) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
            ce = 1'b1;
            addr = $urandom;
            addr[AW+1:2] = idx[AW-1:0];
            #1;
            checks++;
            if (inst !== model_mem[idx]) begin
                errors++;
                $display("[TB] FAIL full_fetch[%0d]: got %h expected %h", idx, inst, model_mem[idx]);
            end
        end
        ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_len_errors();
        test_valid_gaps();
        test_back_to_back();
        test_start_ignored();
        test_reset_during_load();
        test_full_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
